// File: rtl/uart_echo_fifo.sv
// Echo buffer between the UART receiver and transmitter: captures received bytes
// into a circular FIFO and replays them in order, one transmitter frame at a time.
module uart_echo_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter bit DROP_ERRORED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_data_avail,
  input  logic [7:0]        i_rx_data_byte,
  input  logic              i_rx_error,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  input  logic              i_clear,
  output logic              o_tx_data_avail,
  output logic [7:0]        o_tx_data_byte,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic [7:0]        o_err_count
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              rx_prev;
  logic              write_evt, storable, push, pop, lost;

  always_comb begin
    write_evt = i_rx_data_avail && !rx_prev;
    storable  = write_evt && !i_clear && !(i_rx_error && DROP_ERRORED);
    // A flush takes precedence over starting a new frame from the head.
    pop       = (state == IDLE) && (o_count != '0) && !i_tx_active && !i_clear;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push      = storable && ((o_count != FULL_COUNT) || pop);
    lost      = storable && (o_count == FULL_COUNT) && !pop;
  end

  always_comb begin
    count_next = o_count;
    if (i_clear)
      count_next = '0;
    else if (push && !pop)
      count_next = o_count + COUNT_ONE;
    else if (pop && !push)
      count_next = o_count - COUNT_ONE;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = WAIT_DONE;
      WAIT_DONE: if (i_tx_done) state_next = GAP;
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= i_rx_data_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rx_prev         <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      o_count         <= '0;
      o_tx_data_avail <= 1'b0;
      o_tx_data_byte  <= 8'h00;
      o_overflow      <= 1'b0;
      o_err_count     <= 8'h00;
    end else begin
      state           <= state_next;
      rx_prev         <= i_rx_data_avail;
      o_count         <= count_next;
      o_tx_data_avail <= pop;

      if (i_clear)
        wr_ptr <= '0;
      else if (push)
        wr_ptr <= wr_ptr + PTR_ONE;

      if (i_clear)
        rd_ptr <= '0;
      else if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      // Read-before-write: a same-cycle push into the head slot is not seen here.
      if (pop)
        o_tx_data_byte <= mem[rd_ptr];

      if (i_clear)
        o_overflow <= 1'b0;
      else if (lost)
        o_overflow <= 1'b1;

      if (i_clear)
        o_err_count <= 8'h00;
      else if (write_evt && i_rx_error && (o_err_count != 8'hFF))
        o_err_count <= o_err_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: a transmitter model collects emitted
// bytes, and each scenario compares them with a queue-based expectation.
module tb_uart_echo_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       i_rx_data_avail;
  logic [7:0] i_rx_data_byte;
  logic       i_rx_error;
  logic       i_tx_active;
  logic       i_tx_done;
  logic       i_clear;
  logic       o_tx_data_avail;
  logic [7:0] o_tx_data_byte;
  logic [4:0] o_count;
  logic       o_overflow;
  logic [7:0] o_err_count;

  logic       hold_active;
  logic       frame_busy;
  int         done_delay;
  int         cyc;
  int         tests_run;
  int         tests_failed;

  logic [7:0] emitted [$];
  int         req_cyc [$];
  int         done_cyc [$];

  assign i_tx_active = hold_active | frame_busy;

  uart_echo_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .DROP_ERRORED(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_rx_data_avail (i_rx_data_avail),
    .i_rx_data_byte  (i_rx_data_byte),
    .i_rx_error      (i_rx_error),
    .i_tx_active     (i_tx_active),
    .i_tx_done       (i_tx_done),
    .i_clear         (i_clear),
    .o_tx_data_avail (o_tx_data_avail),
    .o_tx_data_byte  (o_tx_data_byte),
    .o_count         (o_count),
    .o_overflow      (o_overflow),
    .o_err_count     (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: records each request, then returns done after done_delay cycles.
  initial begin
    frame_busy = 1'b0;
    i_tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_data_avail === 1'b1) begin
        emitted.push_back(o_tx_data_byte);
        req_cyc.push_back(cyc);
        $display("[TB] tx request byte=%02h at cycle %0d", o_tx_data_byte, cyc);
        frame_busy = 1'b1;
        repeat (done_delay) @(negedge clk);
        i_tx_done  = 1'b1;
        frame_busy = 1'b0;
        done_cyc.push_back(cyc);
        @(negedge clk);
        i_tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk);
    i_rx_data_avail = 1'b1;
    i_rx_data_byte  = b;
    i_rx_error      = err;
    @(negedge clk);
    i_rx_data_avail = 1'b0;
    i_rx_error      = 1'b0;
    $display("[TB] rx write byte=%02h err=%0b count=%0d", b, err, o_count);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic reset_log();
    emitted.delete();
    req_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_count !== 5'd0 || o_tx_data_avail !== 1'b0 || o_tx_data_byte !== 8'h00 ||
        o_overflow !== 1'b0 || o_err_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d avail=%0b byte=%02h ovf=%0b err=%0d, required all 0",
               o_count, o_tx_data_avail, o_tx_data_byte, o_overflow, o_err_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b;
    reset_log();
    done_delay = 20;
    b = 8'h41;
    send_byte(b, 1'b0);
    tests_run++;
    if (o_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL single_count_after_write: got %0d, required 1", o_count);
    end
    @(negedge clk);
    tests_run++;
    if (o_tx_data_avail !== 1'b1 || o_tx_data_byte !== b || o_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL single_request: avail=%0b byte=%02h count=%0d, required 1/%02h/0",
               o_tx_data_avail, o_tx_data_byte, o_count, b);
    end
    @(negedge clk);
    tests_run++;
    if (o_tx_data_avail !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_request_width: avail=%0b one cycle later, required 0", o_tx_data_avail);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (o_tx_data_byte !== b) begin
      tests_failed++;
      $display("FAIL single_byte_held: got %02h, required %02h", o_tx_data_byte, b);
    end
    repeat (done_delay) @(negedge clk);
    tests_run++;
    if (emitted.size() !== 1) begin
      tests_failed++;
      $display("FAIL single_emit_count: got %0d, required 1", emitted.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    int         n_req;
    reset_log();
    done_delay  = 5;
    hold_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = (i < 5) ? 8'(8'h30 + i) : 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b0);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (o_count !== 5'd10 || emitted.size() !== 0) begin
      tests_failed++;
      $display("FAIL burst_hold: count=%0d emitted=%0d, required 10/0", o_count, emitted.size());
    end
    hold_active = 1'b0;
    for (int k = 0; k < 1000 && emitted.size() < exp_q.size(); k++) @(negedge clk);
    repeat (done_delay + 4) @(negedge clk);
    tests_run++;
    if (emitted.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL burst_emit_count: got %0d, required %0d", emitted.size(), exp_q.size());
    end
    n_req = (emitted.size() < exp_q.size()) ? emitted.size() : exp_q.size();
    for (int i = 0; i < n_req; i++) begin
      tests_run++;
      if (emitted[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL burst_order[%0d]: got %02h, required %02h", i, emitted[i], exp_q[i]);
      end
    end
    for (int i = 1; i < n_req && i < done_cyc.size() + 1; i++) begin
      tests_run++;
      if (req_cyc[i] - done_cyc[i-1] < 3) begin
        tests_failed++;
        $display("FAIL burst_gap[%0d]: request %0d cycles after done, required >= 3",
                 i, req_cyc[i] - done_cyc[i-1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [$];
    reset_log();
    done_delay  = 3;
    hold_active = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (i < DEPTH) exp_q.push_back(b);
      send_byte(b, 1'b0);
    end
    tests_run++;
    if (o_count !== 5'(DEPTH) || o_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_full: count=%0d ovf=%0b, required %0d/1", o_count, o_overflow, DEPTH);
    end
    hold_active = 1'b0;
    for (int k = 0; k < 1000 && emitted.size() < DEPTH; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    tests_run++;
    if (emitted.size() !== DEPTH) begin
      tests_failed++;
      $display("FAIL overflow_emit_count: got %0d, required %0d", emitted.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < emitted.size(); i++) begin
      tests_run++;
      if (emitted[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL overflow_order[%0d]: got %02h, required %02h", i, emitted[i], exp_q[i]);
      end
    end
    hold_active = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    pulse_clear();
    tests_run++;
    if (o_count !== 5'd0 || o_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: count=%0d ovf=%0b, required 0/0", o_count, o_overflow);
    end
    hold_active = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (emitted.size() !== DEPTH) begin
      tests_failed++;
      $display("FAIL clear_flushes: emitted %0d, required %0d", emitted.size(), DEPTH);
    end
  endtask

  task automatic test_parity();
    logic [7:0] exp_q [$];
    int         exp_err;
    reset_log();
    done_delay = 3;
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (o_err_count !== 8'd1 || o_count !== 5'd0 || emitted.size() !== 0) begin
      tests_failed++;
      $display("FAIL parity_drop: err=%0d count=%0d emitted=%0d, required 1/0/0",
               o_err_count, o_count, emitted.size());
    end
    for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    tests_run++;
    if (o_err_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL parity_saturate: got %0d, required 255", o_err_count);
    end
    pulse_clear();
    hold_active = 1'b1;
    exp_err = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       e;
      b = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 2) == 0);
      if (e) exp_err++;
      else exp_q.push_back(b);
      send_byte(b, e);
    end
    tests_run++;
    if (o_err_count !== 8'(exp_err) || o_count !== 5'(exp_q.size())) begin
      tests_failed++;
      $display("FAIL parity_mix: err=%0d count=%0d, required %0d/%0d",
               o_err_count, o_count, exp_err, exp_q.size());
    end
    hold_active = 1'b0;
    for (int k = 0; k < 1000 && emitted.size() < exp_q.size(); k++) @(negedge clk);
    repeat (10) @(negedge clk);
    tests_run++;
    if (emitted.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL parity_mix_emit_count: got %0d, required %0d", emitted.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
      tests_run++;
      if (emitted[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL parity_mix_order[%0d]: got %02h, required %02h", i, emitted[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_level_and_push_pop();
    logic [7:0] exp_q [$];
    logic [7:0] extra;
    reset_log();
    done_delay  = 4;
    hold_active = 1'b1;
    @(negedge clk);
    i_rx_data_avail = 1'b1;
    i_rx_data_byte  = 8'($urandom_range(0, 255));
    exp_q.push_back(i_rx_data_byte);
    repeat (10) @(negedge clk);
    i_rx_data_avail = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL level_single_write: count=%0d, required 1", o_count);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b0);
    end
    tests_run++;
    if (o_count !== 5'(DEPTH)) begin
      tests_failed++;
      $display("FAIL pushpop_fill: count=%0d, required %0d", o_count, DEPTH);
    end
    // New byte arrives on the very edge where the head is popped.
    extra = 8'($urandom_range(0, 255));
    exp_q.push_back(extra);
    @(negedge clk);
    hold_active     = 1'b0;
    i_rx_data_avail = 1'b1;
    i_rx_data_byte  = extra;
    @(negedge clk);
    i_rx_data_avail = 1'b0;
    tests_run++;
    if (o_count !== 5'(DEPTH) || o_overflow !== 1'b0 || o_tx_data_avail !== 1'b1 ||
        o_tx_data_byte !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL pushpop_same_cycle: count=%0d ovf=%0b avail=%0b byte=%02h, required %0d/0/1/%02h",
               o_count, o_overflow, o_tx_data_avail, o_tx_data_byte, DEPTH, exp_q[0]);
    end
    for (int k = 0; k < 2000 && emitted.size() < exp_q.size(); k++) @(negedge clk);
    repeat (12) @(negedge clk);
    tests_run++;
    if (emitted.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL pushpop_emit_count: got %0d, required %0d", emitted.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
      tests_run++;
      if (emitted[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL pushpop_order[%0d]: got %02h, required %02h", i, emitted[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         seen;
    reset_log();
    done_delay  = 30;
    hold_active = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'h7E, 1'b1);
    hold_active = 1'b0;
    for (int k = 0; k < 50 && emitted.size() < 1; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (o_count !== 5'd0 || o_tx_data_avail !== 1'b0 || o_tx_data_byte !== 8'h00 ||
        o_overflow !== 1'b0 || o_err_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d avail=%0b byte=%02h ovf=%0b err=%0d, required all 0",
               o_count, o_tx_data_avail, o_tx_data_byte, o_overflow, o_err_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = emitted.size();
    repeat (50) @(negedge clk);
    tests_run++;
    if (emitted.size() !== seen) begin
      tests_failed++;
      $display("FAIL reset_no_request: emitted %0d, required %0d", emitted.size(), seen);
    end
    done_delay = 4;
    b = 8'($urandom_range(0, 255));
    send_byte(b, 1'b0);
    for (int k = 0; k < 50 && emitted.size() < seen + 1; k++) @(negedge clk);
    tests_run++;
    if (emitted.size() !== seen + 1 || (emitted.size() > seen && emitted[seen] !== b)) begin
      tests_failed++;
      $display("FAIL reset_recover: emitted %0d, required %0d with byte %02h", emitted.size(), seen + 1, b);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    done_delay      = 20;
    hold_active     = 1'b0;
    reset           = 1'b0;
    i_rx_data_avail = 1'b0;
    i_rx_data_byte  = 8'h00;
    i_rx_error      = 1'b0;
    i_clear         = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_level_and_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
